mips_multicycle_control: RTL and testbench

//   Multicycle MIPS main-control FSM; the driver side of the ALU interface. Sequences

---
 rtl/mips_multicycle_control.sv | 249 ++++++++++++++++++++++++
 tb/tb_mips_multicycle_control.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS main-control FSM: sequences fetch/decode/execute/memory/writeback
// and drives ALU operation, datapath mux selects and write enables.
//
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   Op, Funct       instruction opcode / function fields from the IR
//   Zero            ALU zero flag (same-cycle), used for branch PC enable
//   ALUControl      000 add, 001 sub, 010 and, 011 or, 101 slt
//   ALUSrcA/B       ALU operand selects
//   IorD            memory address select (PC / ALUOut)
//   MemWrite        data memory write enable
//   IRWrite         instruction register load
//   RegDst          write register select (rt / rd)
//   MemtoReg        write-back data select (ALUOut / Data)
//   RegWrite        register file write enable
//   PCSrc           PC source select (ALUResult / ALUOut / jump target)
//   PCEn            PC load enable
//   IllegalOp       illegal opcode/funct indicator
//
// Parameter ILLEGAL_TO_FETCH: 1 treats illegal op/funct as NOP, 0 parks in HALT.
// Macro BNE_EN: when defined, opcode 000101 (bne) is decoded; otherwise illegal.

module mips_multicycle_control #(
   parameter bit ILLEGAL_TO_FETCH = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] Op,
   input  logic [5:0] Funct,
   input  logic       Zero,
   output logic [2:0] ALUControl,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic       IorD,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegDst,
   output logic       MemtoReg,
   output logic       RegWrite,
   output logic [1:0] PCSrc,
   output logic       PCEn,
   output logic       IllegalOp
);

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_RTYPEEX = 4'd6,
      S_RTYPEWB = 4'd7,
      S_BEQEX   = 4'd8,
      S_ADDIEX  = 4'd9,
      S_ADDIWB  = 4'd10,
      S_JEX     = 4'd11,
      S_BNEEX   = 4'd12,
      S_HALT    = 4'd13
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   state_t     state;
   state_t     state_next;
   state_t     illegal_next;
   state_t     decode_next;
   logic       op_illegal;
   logic       funct_ok;
   logic [2:0] funct_alu;
   logic       pc_write;
   logic       branch;
   logic       branch_inv;

   // Where an illegal op/funct sends the machine.
   always_comb begin
      if (ILLEGAL_TO_FETCH) illegal_next = S_FETCH;
      else                  illegal_next = S_HALT;
   end

   // Opcode decode, only meaningful while in DECODE (IR stable).
   always_comb begin
      decode_next = illegal_next;
      op_illegal  = 1'b0;
      case (Op)
         OP_LW,
         OP_SW:    decode_next = S_MEMADR;
         OP_RTYPE: decode_next = S_RTYPEEX;
         OP_BEQ:   decode_next = S_BEQEX;
         OP_ADDI:  decode_next = S_ADDIEX;
         OP_J:     decode_next = S_JEX;
`ifdef BNE_EN
         OP_BNE:   decode_next = S_BNEEX;
`endif
         default:  op_illegal  = 1'b1;
      endcase
   end

   // R-type function decode.
   always_comb begin
      funct_alu = ALU_ADD;
      funct_ok  = 1'b1;
      case (Funct)
         FN_ADD:  funct_alu = ALU_ADD;
         FN_SUB:  funct_alu = ALU_SUB;
         FN_AND:  funct_alu = ALU_AND;
         FN_OR:   funct_alu = ALU_OR;
         FN_SLT:  funct_alu = ALU_SLT;
         default: funct_ok  = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state <= S_FETCH;
      else       state <= state_next;
   end

   // Moore outputs and next state. Reset overrides to FETCH values with
   // every enable held low, which also kills a write pending mid-instruction.
   always_comb begin
      state_next = S_FETCH;
      ALUControl = ALU_ADD;
      ALUSrcA    = 1'b0;
      ALUSrcB    = 2'b00;
      IorD       = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      RegDst     = 1'b0;
      MemtoReg   = 1'b0;
      RegWrite   = 1'b0;
      PCSrc      = 2'b00;
      IllegalOp  = 1'b0;
      pc_write   = 1'b0;
      branch     = 1'b0;
      branch_inv = 1'b0;

      case (state)
         S_FETCH: begin
            IRWrite    = 1'b1;
            ALUSrcB    = 2'b01;
            pc_write   = 1'b1;
            state_next = S_DECODE;
         end
         S_DECODE: begin
            ALUSrcB    = 2'b11;
            IllegalOp  = op_illegal;
            state_next = decode_next;
         end
         S_MEMADR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            if (Op == OP_SW) state_next = S_MEMWR;
            else             state_next = S_MEMRD;
         end
         S_MEMRD: begin
            IorD       = 1'b1;
            state_next = S_MEMWB;
         end
         S_MEMWB: begin
            MemtoReg = 1'b1;
            RegWrite = 1'b1;
         end
         S_MEMWR: begin
            IorD     = 1'b1;
            MemWrite = 1'b1;
         end
         S_RTYPEEX: begin
            ALUSrcA    = 1'b1;
            ALUControl = funct_alu;
            IllegalOp  = ~funct_ok;
            if (funct_ok) state_next = S_RTYPEWB;
            else          state_next = illegal_next;
         end
         S_RTYPEWB: begin
            RegDst   = 1'b1;
            RegWrite = 1'b1;
         end
         S_BEQEX: begin
            ALUSrcA    = 1'b1;
            ALUControl = ALU_SUB;
            PCSrc      = 2'b01;
            branch     = 1'b1;
         end
`ifdef BNE_EN
         S_BNEEX: begin
            ALUSrcA    = 1'b1;
            ALUControl = ALU_SUB;
            PCSrc      = 2'b01;
            branch_inv = 1'b1;
         end
`endif
         S_ADDIEX: begin
            ALUSrcA    = 1'b1;
            ALUSrcB    = 2'b10;
            state_next = S_ADDIWB;
         end
         S_ADDIWB: begin
            RegWrite = 1'b1;
         end
         S_JEX: begin
            PCSrc    = 2'b10;
            pc_write = 1'b1;
         end
         S_HALT: begin
            IllegalOp  = 1'b1;
            state_next = S_HALT;
         end
         default: begin
            state_next = S_FETCH;
         end
      endcase

      PCEn = pc_write | (branch & Zero) | (branch_inv & ~Zero);

      if (reset) begin
         ALUControl = ALU_ADD;
         ALUSrcA    = 1'b0;
         ALUSrcB    = 2'b01;
         IorD       = 1'b0;
         MemWrite   = 1'b0;
         IRWrite    = 1'b0;
         RegDst     = 1'b0;
         MemtoReg   = 1'b0;
         RegWrite   = 1'b0;
         PCSrc      = 2'b00;
         PCEn       = 1'b0;
         IllegalOp  = 1'b0;
      end
   end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed bench for mips_multicycle_control: per-cycle output vectors
// for each instruction class, illegal handling, HALT and mid-instruction reset.

module tb_mips_multicycle_control;

   logic       clk = 1'b0;
   logic       reset;
   logic       reset_h;
   logic [5:0] Op;
   logic [5:0] Funct;
   logic       Zero;

   logic [2:0] alu_c,  alu_c_h;
   logic       srca,   srca_h;
   logic [1:0] srcb,   srcb_h;
   logic       iord,   iord_h;
   logic       mw,     mw_h;
   logic       irw,    irw_h;
   logic       rdst,   rdst_h;
   logic       m2r,    m2r_h;
   logic       rw,     rw_h;
   logic [1:0] pcs,    pcs_h;
   logic       pcen,   pcen_h;
   logic       ill,    ill_h;

   logic [15:0] sig, sig_h;

   int checks = 0;
   int errors = 0;

   // Packed as {ALUControl,SrcA,SrcB,IorD,MemWrite,IRWrite,
   //            RegDst,MemtoReg,RegWrite,PCSrc,PCEn,IllegalOp}
   localparam logic [15:0] V_FETCH  = 16'b000_0_01_0_0_1_0_0_0_00_1_0;
   localparam logic [15:0] V_RST    = 16'b000_0_01_0_0_0_0_0_0_00_0_0;
   localparam logic [15:0] V_DEC    = 16'b000_0_11_0_0_0_0_0_0_00_0_0;
   localparam logic [15:0] V_DECI   = 16'b000_0_11_0_0_0_0_0_0_00_0_1;
   localparam logic [15:0] V_MEMADR = 16'b000_1_10_0_0_0_0_0_0_00_0_0;
   localparam logic [15:0] V_MEMRD  = 16'b000_0_00_1_0_0_0_0_0_00_0_0;
   localparam logic [15:0] V_MEMWB  = 16'b000_0_00_0_0_0_0_1_1_00_0_0;
   localparam logic [15:0] V_MEMWR  = 16'b000_0_00_1_1_0_0_0_0_00_0_0;
   localparam logic [15:0] V_RWB    = 16'b000_0_00_0_0_0_1_0_1_00_0_0;
   localparam logic [15:0] V_RILL   = 16'b000_1_00_0_0_0_0_0_0_00_0_1;
   localparam logic [15:0] V_BR1    = 16'b001_1_00_0_0_0_0_0_0_01_1_0;
   localparam logic [15:0] V_BR0    = 16'b001_1_00_0_0_0_0_0_0_01_0_0;
   localparam logic [15:0] V_ADDIWB = 16'b000_0_00_0_0_0_0_0_1_00_0_0;
   localparam logic [15:0] V_JEX    = 16'b000_0_00_0_0_0_0_0_0_10_1_0;
   localparam logic [15:0] V_HALT   = 16'b000_0_00_0_0_0_0_0_0_00_0_1;
   localparam logic [12:0] RX_LOW   = 13'b1_00_0_0_0_0_0_0_00_0_0;

   mips_multicycle_control #(.ILLEGAL_TO_FETCH(1'b1)) u_dut (
      .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Zero(Zero),
      .ALUControl(alu_c), .ALUSrcA(srca), .ALUSrcB(srcb), .IorD(iord),
      .MemWrite(mw), .IRWrite(irw), .RegDst(rdst), .MemtoReg(m2r),
      .RegWrite(rw), .PCSrc(pcs), .PCEn(pcen), .IllegalOp(ill)
   );

   mips_multicycle_control #(.ILLEGAL_TO_FETCH(1'b0)) u_halt (
      .clk(clk), .reset(reset_h), .Op(Op), .Funct(Funct), .Zero(Zero),
      .ALUControl(alu_c_h), .ALUSrcA(srca_h), .ALUSrcB(srcb_h),
      .IorD(iord_h), .MemWrite(mw_h), .IRWrite(irw_h), .RegDst(rdst_h),
      .MemtoReg(m2r_h), .RegWrite(rw_h), .PCSrc(pcs_h), .PCEn(pcen_h),
      .IllegalOp(ill_h)
   );

   assign sig   = {alu_c, srca, srcb, iord, mw, irw,
                   rdst, m2r, rw, pcs, pcen, ill};
   assign sig_h = {alu_c_h, srca_h, srcb_h, iord_h, mw_h, irw_h,
                   rdst_h, m2r_h, rw_h, pcs_h, pcen_h, ill_h};

   always #5 clk = ~clk;

   task automatic test_reset();
      reset = 1'b1; reset_h = 1'b1;
      Op = 6'd0; Funct = 6'd0; Zero = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk); #1;
         checks++;
         if (sig !== V_RST) begin
            errors++;
            $display("FAIL reset cyc%0d got %h want %h", i, sig, V_RST);
         end
      end
      reset = 1'b0; #1;
      checks++;
      if (sig !== V_FETCH) begin
         errors++;
         $display("FAIL reset_release got %h want %h", sig, V_FETCH);
      end
      checks++;
      if (sig_h !== V_RST) begin
         errors++;
         $display("FAIL halt_dut_in_reset got %h want %h", sig_h, V_RST);
      end
   endtask

   task automatic test_lw();
      logic [15:0] e [6];
      e = '{V_FETCH, V_DEC, V_MEMADR, V_MEMRD, V_MEMWB, V_FETCH};
      Op = 6'b100011; Zero = 1'b0;
      for (int i = 0; i < 6; i++) begin
         #1;
         checks++;
         if (sig !== e[i]) begin
            errors++;
            $display("FAIL lw cyc%0d got %h want %h", i, sig, e[i]);
         end
         if (i < 5) @(negedge clk);
      end
   endtask

   task automatic test_sw();
      logic [15:0] e [5];
      e = '{V_FETCH, V_DEC, V_MEMADR, V_MEMWR, V_FETCH};
      Op = 6'b101011;
      for (int i = 0; i < 5; i++) begin
         #1;
         checks++;
         if (sig !== e[i]) begin
            errors++;
            $display("FAIL sw cyc%0d got %h want %h", i, sig, e[i]);
         end
         if (i < 4) @(negedge clk);
      end
   endtask

   task automatic test_rtype();
      logic [5:0]  fn [5];
      logic [2:0]  ac [5];
      logic [15:0] e  [5];
      fn = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
      ac = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b101};
      Op = 6'b000000;
      for (int f = 0; f < 5; f++) begin
         Funct = fn[f];
         e = '{V_FETCH, V_DEC, {ac[f], RX_LOW}, V_RWB, V_FETCH};
         for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (sig !== e[i]) begin
               errors++;
               $display("FAIL rtype fn%h cyc%0d got %h want %h",
                        fn[f], i, sig, e[i]);
            end
            if (i < 4) @(negedge clk);
         end
      end
   endtask

   task automatic test_rtype_illegal();
      logic [15:0] e [4];
      e = '{V_FETCH, V_DEC, V_RILL, V_FETCH};
      Op = 6'b000000; Funct = 6'b000111;
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++;
         if (sig !== e[i]) begin
            errors++;
            $display("FAIL rtype_ill cyc%0d got %h want %h", i, sig, e[i]);
         end
         if (i < 3) @(negedge clk);
      end
      Funct = 6'b100000;
   endtask

   task automatic test_beq();
      logic [15:0] e [4];
      for (int z = 0; z < 2; z++) begin
         Op = 6'b000100;
         Zero = (z == 0);
         e = '{V_FETCH, V_DEC, (z == 0) ? V_BR1 : V_BR0, V_FETCH};
         for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (sig !== e[i]) begin
               errors++;
               $display("FAIL beq z%0d cyc%0d got %h want %h",
                        Zero, i, sig, e[i]);
            end
            if (i < 3) @(negedge clk);
         end
      end
      Zero = 1'b0;
   endtask

   task automatic test_addi();
      logic [15:0] e [5];
      e = '{V_FETCH, V_DEC, V_MEMADR, V_ADDIWB, V_FETCH};
      Op = 6'b001000;
      for (int i = 0; i < 5; i++) begin
         #1;
         checks++;
         if (sig !== e[i]) begin
            errors++;
            $display("FAIL addi cyc%0d got %h want %h", i, sig, e[i]);
         end
         if (i < 4) @(negedge clk);
      end
   endtask

   task automatic test_jump();
      logic [15:0] e [4];
      e = '{V_FETCH, V_DEC, V_JEX, V_FETCH};
      Op = 6'b000010;
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++;
         if (sig !== e[i]) begin
            errors++;
            $display("FAIL j cyc%0d got %h want %h", i, sig, e[i]);
         end
         if (i < 3) @(negedge clk);
      end
   endtask

   task automatic test_bne();
      logic [15:0] e [4];
      for (int z = 0; z < 2; z++) begin
         Op = 6'b000101;
         Zero = (z == 1);
`ifdef BNE_EN
         e = '{V_FETCH, V_DEC, (z == 0) ? V_BR1 : V_BR0, V_FETCH};
`else
         e = '{V_FETCH, V_DECI, V_FETCH, V_DECI};
`endif
         for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (sig !== e[i]) begin
               errors++;
               $display("FAIL bne z%0d cyc%0d got %h want %h",
                        Zero, i, sig, e[i]);
            end
            if (i < 3) @(negedge clk);
         end
`ifndef BNE_EN
         @(negedge clk);
`endif
      end
      Zero = 1'b0;
   endtask

   task automatic test_illegal_halt();
      logic [15:0] eu [7];
      logic [15:0] eh [7];
      eu = '{V_FETCH, V_DECI, V_FETCH, V_DECI, V_FETCH, V_DECI, V_FETCH};
      eh = '{V_FETCH, V_DECI, V_HALT, V_HALT, V_RST, V_RST, V_RST};
      reset_h = 1'b0;
      Op = 6'b111111;
      for (int i = 0; i < 7; i++) begin
         if (i == 4) reset_h = 1'b1;
         #1;
         checks++;
         if (sig !== eu[i]) begin
            errors++;
            $display("FAIL ill_fetch cyc%0d got %h want %h", i, sig, eu[i]);
         end
         checks++;
         if (sig_h !== eh[i]) begin
            errors++;
            $display("FAIL ill_halt cyc%0d got %h want %h", i, sig_h, eh[i]);
         end
         if (i < 6) @(negedge clk);
      end
   endtask

   task automatic test_reset_in_memwr();
      logic [15:0] e [3];
      e = '{V_FETCH, V_DEC, V_MEMADR};
      Op = 6'b101011;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if (sig !== e[i]) begin
            errors++;
            $display("FAIL rst_sw cyc%0d got %h want %h", i, sig, e[i]);
         end
         @(negedge clk);
      end
      reset = 1'b1; #1;
      checks++;
      if (sig !== V_RST) begin
         errors++;
         $display("FAIL rst_in_memwr got %h want %h", sig, V_RST);
      end
      @(negedge clk);
      reset = 1'b0; #1;
      checks++;
      if (sig !== V_FETCH) begin
         errors++;
         $display("FAIL rst_then_fetch got %h want %h", sig, V_FETCH);
      end
   endtask

   initial begin
      test_reset();
      test_lw();
      test_sw();
      test_rtype();
      test_rtype_illegal();
      test_beq();
      test_addi();
      test_jump();
      test_bne();
      test_illegal_halt();
      test_reset_in_memwr();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
